// File: rtl/counter_pkg.sv
// Shared types and default widths for the up/down modulo counter.
package counter_pkg;

  localparam int DEFAULT_WORD_LENGTH    = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } count_mode_e;

  // What an enabled step does to the count, decided before the priority mux.
  typedef enum logic [1:0] {
    STEP_MOVE = 2'd0,
    STEP_WRAP = 2'd1,
    STEP_HOLD = 2'd2
  } step_kind_e;

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles: tick is high on every (div+1)-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = 1;

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [DIV_WIDTH-1:0] cnt_next;

  // >= keeps the divider from running away if div shrinks below the count.
  assign tick = (cnt_reg >= div);

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = tick ? '0 : cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/updown_modulo_counter.sv
// Up/down modulo counter with wrap/saturate modes, load and sync clear.
// Optional prescaler is built only when CNT_PRESCALE_EN is defined.
module updown_modulo_counter
  import counter_pkg::*;
#(
  parameter int WORD_LENGTH    = DEFAULT_WORD_LENGTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sync_reset,
  input  logic                      load,
  input  logic [WORD_LENGTH-1:0]    load_value,
  input  logic                      up_down,
  input  logic                      sat_mode,
  input  logic [WORD_LENGTH-1:0]    modulus,
  input  logic [PRESCALE_WIDTH-1:0] prescale_div,
  output logic [WORD_LENGTH-1:0]    count_out,
  output logic                      finish_count,
  output logic                      tc_pulse
);

  localparam logic [WORD_LENGTH-1:0] ONE = 1;

  logic [WORD_LENGTH-1:0] count_reg;
  logic [WORD_LENGTH-1:0] count_next;
  logic                   tc_pulse_reg;
  logic                   tc_pulse_next;
  logic                   sat_flag_reg;
  logic                   sat_flag_next;

  logic [WORD_LENGTH-1:0] tv;
  logic                   tick;
  logic                   step;
  count_dir_e             dir;
  count_mode_e            mode;
  step_kind_e             kind;

  assign dir  = count_dir_e'(up_down);
  assign mode = count_mode_e'(sat_mode);

  // Modulus 0 stands for the full 2^WORD_LENGTH range.
  assign tv = (modulus == '0) ? '1 : (modulus - ONE);

`ifdef CNT_PRESCALE_EN
  logic prescale_clear;

  assign prescale_clear = sync_reset | load;

  counter_prescaler #(
    .DIV_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (prescale_clear),
    .div    (prescale_div),
    .tick   (tick)
  );
`else
  logic unused_prescale_div;

  assign tick                = 1'b1;
  assign unused_prescale_div = ^prescale_div;
`endif

  assign step = enable & tick;

  always_comb begin
    kind = STEP_MOVE;
    if (count_reg > tv) begin
      kind = STEP_WRAP;
    end else if (((dir == DIR_UP) && (count_reg == tv)) ||
                 ((dir == DIR_DOWN) && (count_reg == '0))) begin
      kind = (mode == MODE_SATURATE) ? STEP_HOLD : STEP_WRAP;
    end
  end

  always_comb begin
    count_next    = count_reg;
    tc_pulse_next = 1'b0;
    sat_flag_next = sat_flag_reg;
    if (sync_reset) begin
      count_next    = '0;
      sat_flag_next = 1'b0;
    end else if (load) begin
      count_next    = (load_value > tv) ? tv : load_value;
      sat_flag_next = 1'b0;
    end else if (step) begin
      unique case (kind)
        STEP_WRAP: begin
          count_next    = (dir == DIR_UP) ? '0 : tv;
          tc_pulse_next = 1'b1;
          sat_flag_next = 1'b0;
        end
        // Only the first held step at a bound reports; the flag re-arms on leaving.
        STEP_HOLD: begin
          tc_pulse_next = ~sat_flag_reg;
          sat_flag_next = 1'b1;
        end
        default: begin
          count_next    = (dir == DIR_UP) ? (count_reg + ONE) : (count_reg - ONE);
          sat_flag_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= '0;
      tc_pulse_reg <= 1'b0;
      sat_flag_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      tc_pulse_reg <= tc_pulse_next;
      sat_flag_reg <= sat_flag_next;
    end
  end

  assign count_out    = count_reg;
  assign tc_pulse     = tc_pulse_reg;
  assign finish_count = (dir == DIR_UP) ? (count_reg == tv) : (count_reg == '0);

endmodule

// File: tb/tb_updown_modulo_counter.sv
// Directed table-driven bench for updown_modulo_counter plus async-reset
// and prescaler sequences.
module tb_updown_modulo_counter;

  localparam int WL = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sync_reset;
  logic          load;
  logic [WL-1:0] load_value;
  logic          up_down;
  logic          sat_mode;
  logic [WL-1:0] modulus;
  logic [PW-1:0] prescale_div;
  logic [WL-1:0] count_out;
  logic          finish_count;
  logic          tc_pulse;

  int vec_count   = 0;
  int miscompares = 0;

  typedef struct {
    logic          sr;
    logic          ld;
    logic [WL-1:0] lv;
    logic          en;
    logic          ud;
    logic          sm;
    logic [WL-1:0] md;
    logic [WL-1:0] ec;
    logic          ef;
    logic          et;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  updown_modulo_counter #(
    .WORD_LENGTH    (WL),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sync_reset   (sync_reset),
    .load         (load),
    .load_value   (load_value),
    .up_down      (up_down),
    .sat_mode     (sat_mode),
    .modulus      (modulus),
    .prescale_div (prescale_div),
    .count_out    (count_out),
    .finish_count (finish_count),
    .tc_pulse     (tc_pulse)
  );

  task automatic add(input logic sr, input logic ld, input logic [WL-1:0] lv,
                     input logic en, input logic ud, input logic sm,
                     input logic [WL-1:0] md, input logic [WL-1:0] ec,
                     input logic ef, input logic et);
    vec_t v;
    v.sr = sr; v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.sm = sm;
    v.md = md; v.ec = ec; v.ef = ef; v.et = et;
    vq.push_back(v);
  endtask

  task automatic drive(input logic sr, input logic ld, input logic [WL-1:0] lv,
                       input logic en, input logic ud, input logic sm,
                       input logic [WL-1:0] md);
    sync_reset = sr; load = ld; load_value = lv; enable = en;
    up_down = ud; sat_mode = sm; modulus = md;
  endtask

  task automatic check(input string name, input logic [WL-1:0] ec,
                       input logic ef, input logic et);
    vec_count++;
    if (count_out !== ec || finish_count !== ef || tc_pulse !== et) begin
      miscompares++;
      $display("FAIL %s: got count=%0d finish=%0b tc=%0b, want count=%0d finish=%0b tc=%0b",
               name, count_out, finish_count, tc_pulse, ec, ef, et);
    end else begin
      $display("ok   %s: count=%0d finish=%0b tc=%0b", name, count_out, finish_count, tc_pulse);
    end
  endtask

  task automatic tick_check(input string name, input logic [WL-1:0] ec,
                            input logic ef, input logic et);
    @(posedge clk);
    #1;
    check(name, ec, ef, et);
  endtask

  initial begin
    //   sr ld  lv  en ud sm  md   ec  ef et
    // up wrap, modulus 5
    add(1, 0,   0, 0, 1, 0,  5,   0, 0, 0);
    add(0, 0,   0, 1, 1, 0,  5,   1, 0, 0);
    add(0, 0,   0, 1, 1, 0,  5,   2, 0, 0);
    add(0, 0,   0, 1, 1, 0,  5,   3, 0, 0);
    add(0, 0,   0, 1, 1, 0,  5,   4, 1, 0);
    add(0, 0,   0, 1, 1, 0,  5,   0, 0, 1);
    add(0, 0,   0, 1, 1, 0,  5,   1, 0, 0);
    add(0, 0,   0, 0, 1, 0,  5,   1, 0, 0);
    // down saturate from load 3 (load wins over enabled step)
    add(0, 1,   3, 1, 0, 1,  5,   3, 0, 0);
    add(0, 0,   0, 1, 0, 1,  5,   2, 0, 0);
    add(0, 0,   0, 1, 0, 1,  5,   1, 0, 0);
    add(0, 0,   0, 1, 0, 1,  5,   0, 1, 0);
    add(0, 0,   0, 1, 0, 1,  5,   0, 1, 1);
    add(0, 0,   0, 1, 0, 1,  5,   0, 1, 0);
    add(0, 0,   0, 1, 1, 1,  5,   1, 0, 0);
    add(0, 0,   0, 1, 0, 1,  5,   0, 1, 0);
    add(0, 0,   0, 1, 0, 1,  5,   0, 1, 1);
    // priority and load clamp
    add(0, 1,   7, 0, 1, 0, 10,   7, 0, 0);
    add(1, 1,   2, 0, 1, 0, 10,   0, 0, 0);
    add(0, 1, 200, 0, 1, 0, 10,   9, 1, 0);
    add(0, 0,   0, 1, 1, 0, 10,   0, 0, 1);
    // modulus shrink below count
    add(0, 1,  12, 0, 1, 0, 16,  12, 0, 0);
    add(0, 0,   0, 1, 1, 0,  8,   0, 0, 1);
    add(0, 1,  12, 0, 1, 0, 16,  12, 0, 0);
    add(0, 0,   0, 1, 0, 0,  8,   7, 0, 1);
    // up saturate at TV
    add(0, 1,   4, 0, 1, 1,  5,   4, 1, 0);
    add(0, 0,   0, 1, 1, 1,  5,   4, 1, 1);
    add(0, 0,   0, 1, 1, 1,  5,   4, 1, 0);
    add(0, 0,   0, 1, 0, 1,  5,   3, 0, 0);
    // modulus 1
    add(1, 0,   0, 0, 1, 0,  1,   0, 1, 0);
    add(0, 0,   0, 1, 1, 0,  1,   0, 1, 1);
    add(0, 0,   0, 1, 0, 0,  1,   0, 1, 1);
    add(0, 0,   0, 0, 0, 0,  1,   0, 1, 0);
    // modulus 0 = full range
    add(0, 1, 255, 0, 1, 0,  0, 255, 1, 0);
    add(0, 0,   0, 1, 1, 0,  0,   0, 0, 1);
    add(0, 0,   0, 1, 0, 0,  0, 255, 0, 1);
    add(0, 0,   0, 1, 0, 0,  0, 254, 0, 0);
    add(0, 1, 200, 0, 0, 0,  0, 200, 0, 0);
    add(1, 0,   0, 1, 0, 0,  0,   0, 1, 0);

    reset        = 1'b0;
    prescale_div = '0;
    drive(0, 0, 0, 0, 1, 0, 5);
    #2;
    check("reset_state", 0, 0, 0);
    #10;
    reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].sr, vq[i].ld, vq[i].lv, vq[i].en, vq[i].ud, vq[i].sm, vq[i].md);
      tick_check($sformatf("vec%0d", i), vq[i].ec, vq[i].ef, vq[i].et);
    end

    // async reset mid-cycle at count 6
    drive(0, 1, 6, 0, 1, 0, 10);
    tick_check("load6", 6, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 10);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_now", 0, 0, 0);
    tick_check("async_rst_held", 0, 0, 0);
    #3;
    reset = 1'b1;
    tick_check("after_release", 1, 0, 0);

    // async reset clears a live tc_pulse
    drive(0, 1, 9, 0, 1, 0, 10);
    tick_check("load9", 9, 1, 0);
    drive(0, 0, 0, 1, 1, 0, 10);
    tick_check("wrap_tc", 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tc", 0, 0, 0);
    #3;
    reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 10);

    // prescaler divide-by-3 over 12 enabled cycles
    prescale_div = 4'd2;
    drive(1, 0, 0, 0, 1, 0, 4);
    tick_check("pre_clear", 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 4);
`ifdef CNT_PRESCALE_EN
    for (int k = 1; k <= 12; k++) begin
      logic [WL-1:0] exp_c;
      exp_c = WL'((k / 3) % 4);
      tick_check($sformatf("pre_cyc%0d", k), exp_c, (exp_c == 3), (k == 12));
    end
`else
    for (int k = 1; k <= 4; k++) begin
      logic [WL-1:0] exp_c;
      exp_c = WL'(k % 4);
      tick_check($sformatf("nopre_cyc%0d", k), exp_c, (exp_c == 3), (k == 4));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
